// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Purpose  : Sequences the byte stream of a UART receiver into framed
//            commands: HEADER, LEN, LEN payload bytes, CHECKSUM.
//            A good frame is published on frame_data/frame_len with a
//            one-cycle frame_valid pulse. Bad length, bad checksum or an
//            inter-byte timeout give a one-cycle frame_err pulse. The parser
//            then waits for the next HEADER byte.
// Ports    : clk         system clock
//            rst         asynchronous active-low reset
//            rx_data     received byte, valid while rx_ready is high
//            rx_ready    receiver level; each rising edge is one byte
//            frame_data  payload, byte i at [BIT_MAX*i +: BIT_MAX]
//            frame_len   payload length of the last good frame
//            frame_valid one-cycle pulse, good frame published
//            frame_err   one-cycle pulse, frame discarded
//            busy        high while a frame is being parsed
//            good_cnt    (RX_FRAME_STATS_EN) saturating good frame count
//            err_cnt     (RX_FRAME_STATS_EN) saturating error count
// Options  : define RX_FRAME_STATS_EN to add the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
    parameter int                 BIT_MAX     = 8,
    parameter logic [BIT_MAX-1:0] HEADER      = BIT_MAX'(8'hAA),
    parameter int                 MAX_LEN     = 8,
    parameter int                 TIMEOUT_MAX = 52080
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BIT_MAX-1:0]         rx_data,
    input  logic                       rx_ready,
    output logic [MAX_LEN*BIT_MAX-1:0] frame_data,
    output logic [3:0]                 frame_len,
    output logic                       frame_valid,
    output logic                       frame_err,
    output logic                       busy
`ifdef RX_FRAME_STATS_EN
    ,
    output logic [15:0]                good_cnt,
    output logic [15:0]                err_cnt
`endif
);

    localparam int TMO_W = $clog2(TIMEOUT_MAX + 1);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LEN     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CHECK   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rx_ready_d;
    logic                 w_strobe;
    logic [BIT_MAX-1:0]   r_sum;
    logic [BIT_MAX-1:0]   w_sum_nxt;
    logic [3:0]           r_len;
    logic [3:0]           w_len_nxt;
    logic [3:0]           r_idx;
    logic [3:0]           w_idx_nxt;
    logic [TMO_W-1:0]     r_tmo;
    logic [TMO_W-1:0]     w_tmo_nxt;
    logic                 w_timeout;
    logic                 w_shadow_we;
    logic                 w_load;
    logic                 w_valid_nxt;
    logic                 w_err_nxt;
    logic                 r_valid;
    logic                 r_err;
    logic [3:0]           r_frame_len;
    logic [BIT_MAX-1:0]   r_shadow     [MAX_LEN];
    logic [BIT_MAX-1:0]   r_frame_slot [MAX_LEN];

    // One byte per rising edge of rx_ready, however long the level is held.
    assign w_strobe  = rx_ready & ~r_rx_ready_d;
    assign w_timeout = (r_state != S_IDLE) && (r_tmo == c_tmo_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_len_nxt   = r_len;
        w_idx_nxt   = r_idx;
        w_shadow_we = 1'b0;
        w_load      = 1'b0;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;

        if (r_state == S_IDLE || w_strobe) begin
            w_tmo_nxt = '0;
        end else begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (w_strobe && rx_data == HEADER) begin
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (w_strobe) begin
                    w_sum_nxt = rx_data;
                    if (rx_data > BIT_MAX'(MAX_LEN)) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_len_nxt = rx_data[3:0];
                        w_idx_nxt = 4'd0;
                        if (rx_data == '0) begin
                            w_state_nxt = S_CHECK;
                        end else begin
                            w_state_nxt = S_PAYLOAD;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_strobe) begin
                    w_shadow_we = 1'b1;
                    w_sum_nxt   = r_sum + rx_data;
                    if (r_idx == r_len - 4'd1) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            S_CHECK: begin
                if (w_strobe) begin
                    if (rx_data == r_sum) begin
                        w_load      = 1'b1;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A byte arriving in the expiry cycle takes precedence over the timeout.
        if (w_timeout && !w_strobe) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
            w_tmo_nxt   = '0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_ready_d <= 1'b0;
            r_sum        <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_tmo        <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_frame_len  <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_shadow[i]     <= '0;
                r_frame_slot[i] <= '0;
            end
        end else begin
            r_rx_ready_d <= rx_ready;
            r_sum        <= w_sum_nxt;
            r_len        <= w_len_nxt;
            r_idx        <= w_idx_nxt;
            r_tmo        <= w_tmo_nxt;
            r_valid      <= w_valid_nxt;
            r_err        <= w_err_nxt;
            for (int i = 0; i < MAX_LEN; i++) begin
                if (w_shadow_we && r_idx == 4'(i)) begin
                    r_shadow[i] <= rx_data;
                end
                // Slots beyond the new length are zeroed so stale bytes of a
                // longer earlier frame never leak into a shorter one.
                if (w_load) begin
                    r_frame_slot[i] <= (i < int'(r_len)) ? r_shadow[i] : '0;
                end
            end
            if (w_load) begin
                r_frame_len <= r_len;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_frame_pack
            assign frame_data[gi*BIT_MAX +: BIT_MAX] = r_frame_slot[gi];
        end
    endgenerate

    assign frame_len   = r_frame_len;
    assign frame_valid = r_valid;
    assign frame_err   = r_err;
    assign busy        = (r_state != S_IDLE);

`ifdef RX_FRAME_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_good_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (r_valid && r_good_cnt != 16'hFFFF) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (r_err && r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign good_cnt = r_good_cnt;
    assign err_cnt  = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame_ctrl
// Purpose  : Directed self-checking bench for uart_rx_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_ctrl;

    localparam int BIT_MAX = 8;
    localparam int MAX_LEN = 8;
    localparam int TB_TMO  = 300;

    logic                       clk;
    logic                       rst;
    logic [BIT_MAX-1:0]         rx_data;
    logic                       rx_ready;
    logic [MAX_LEN*BIT_MAX-1:0] frame_data;
    logic [3:0]                 frame_len;
    logic                       frame_valid;
    logic                       frame_err;
    logic                       busy;
`ifdef RX_FRAME_STATS_EN
    logic [15:0]                good_cnt;
    logic [15:0]                err_cnt;
`endif

    uart_rx_frame_ctrl #(
        .BIT_MAX     (BIT_MAX),
        .HEADER      (8'hAA),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_MAX (TB_TMO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .frame_data  (frame_data),
        .frame_len   (frame_len),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy)
`ifdef RX_FRAME_STATS_EN
        ,
        .good_cnt    (good_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;
    int ecnt    = 0;
    int v0      = 0;
    int e0      = 0;
    logic both_seen = 1'b0;
    logic [7:0] q[$];

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_valid) vcnt++;
        if (frame_err)   ecnt++;
        if (frame_valid && frame_err) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge. rx_ready is high across
    // `hold` rising edges and low across `gap` rising edges.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (hold) @(negedge clk);
        rx_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_q();
        foreach (q[i]) send_byte(q[i], 2, 2);
    endtask

    task automatic snap();
        v0 = vcnt;
        e0 = ecnt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        rx_data  = '0;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst valid", frame_valid, 0);
        check("rst err",   frame_err,   0);
        check("rst busy",  busy,        0);
        check("rst len",   frame_len,   0);
        check("rst data",  frame_data,  0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Good 3-byte frame
        snap();
        q = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_q();
        check("t1 valid", vcnt - v0, 1);
        check("t1 err",   ecnt - e0, 0);
        check("t1 len",   frame_len, 3);
        check("t1 data",  frame_data, 64'h0000_0000_0033_2211);
        check("t1 busy",  busy, 0);

        // Bad checksum keeps the previous frame
        snap();
        q = '{8'hAA, 8'h02, 8'h10, 8'h20, 8'h00};
        send_q();
        check("t2 err",   ecnt - e0, 1);
        check("t2 valid", vcnt - v0, 0);
        check("t2 len",   frame_len, 3);
        check("t2 data",  frame_data, 64'h0000_0000_0033_2211);
        check("t2 busy",  busy, 0);

        // Junk byte before header, zero-length frame
        snap();
        q = '{8'h55, 8'hAA, 8'h00, 8'h00};
        send_q();
        check("t3 err",   ecnt - e0, 0);
        check("t3 valid", vcnt - v0, 1);
        check("t3 len",   frame_len, 0);
        check("t3 data",  frame_data, 0);

        // Over-length then recovery
        snap();
        q = '{8'hAA, 8'h09};
        send_q();
        check("t4 lenerr", ecnt - e0, 1);
        check("t4 busy",   busy, 0);
        snap();
        q = '{8'hAA, 8'h01, 8'h05, 8'h06};
        send_q();
        check("t4 valid", vcnt - v0, 1);
        check("t4 err",   ecnt - e0, 0);
        check("t4 len",   frame_len, 1);
        check("t4 data",  frame_data, 64'h05);

        // Plain inter-byte timeout
        snap();
        send_byte(8'hAA, 2, 2);
        send_byte(8'h02, 2, 2);
        send_byte(8'h01, 2, TB_TMO + 5);
        check("t5 tmo err",   ecnt - e0, 1);
        check("t5 tmo valid", vcnt - v0, 0);
        check("t5 tmo busy",  busy, 0);

        // Next byte lands exactly in the expiry cycle: no error
        snap();
        send_byte(8'hAA, 2, 2);
        send_byte(8'h02, 2, 2);
        send_byte(8'h01, 2, TB_TMO - 2);
        send_byte(8'h02, 2, 2);
        send_byte(8'h05, 2, 2);
        check("t5 edge err",   ecnt - e0, 0);
        check("t5 edge valid", vcnt - v0, 1);
        check("t5 edge len",   frame_len, 2);
        check("t5 edge data",  frame_data, 64'h0201);

        // One cycle later: timeout fires, late byte dropped in IDLE
        snap();
        send_byte(8'hAA, 2, 2);
        send_byte(8'h02, 2, 2);
        send_byte(8'h01, 2, TB_TMO - 1);
        send_byte(8'h02, 2, 2);
        check("t5 late err",   ecnt - e0, 1);
        check("t5 late valid", vcnt - v0, 0);
        check("t5 late busy",  busy, 0);
        check("t5 late data",  frame_data, 64'h0201);

        // Long rx_ready levels count as single bytes
        snap();
        send_byte(8'hAA, 60, 2);
        send_byte(8'h03, 60, 2);
        send_byte(8'hA1, 60, 2);
        send_byte(8'hB2, 60, 2);
        send_byte(8'hC3, 60, 2);
        send_byte(8'h19, 60, 2);
        check("t6 valid", vcnt - v0, 1);
        check("t6 err",   ecnt - e0, 0);
        check("t6 len",   frame_len, 3);
        check("t6 data",  frame_data, 64'hC3_B2A1);

        // Reset mid-payload
        q = '{8'hAA, 8'h04, 8'h01, 8'h02};
        send_q();
        check("t7 busy pre", busy, 1);
        rst = 1'b0;
        #1;
        check("t7 rst busy", busy, 0);
        check("t7 rst len",  frame_len, 0);
        check("t7 rst data", frame_data, 0);
        check("t7 rst flags", {frame_valid, frame_err}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        snap();
        q = '{8'hAA, 8'h01, 8'h7F, 8'h80};
        send_q();
        check("t7 valid", vcnt - v0, 1);
        check("t7 err",   ecnt - e0, 0);
        check("t7 len",   frame_len, 1);
        check("t7 data",  frame_data, 64'h7F);
`ifdef RX_FRAME_STATS_EN
        check("stats good", good_cnt, 1);
        check("stats err",  err_cnt,  0);
`endif
        check("never both", both_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
